// File: rtl/serie_paralelo_if.sv
// Serial-in / parallel-out bus bundle.
//   master : drives the serial side (ena_in, ser_in) and observes the word side
//   slave  : the converter; receives serial bits, returns dout/dout_valid/busy/par_err
// Ports:
//   ena_in     frame-start strobe, high with data bit 0
//   ser_in     serial data, LSB first
//   dout       last completed parallel word
//   dout_valid one-cycle pulse when dout updates
//   busy       frame collection in progress
//   par_err    parity error, meaningful only with dout_valid
interface serie_paralelo_if #(parameter int WIDTH = 6);
  logic             ena_in;
  logic             ser_in;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             par_err;

  modport master (output ena_in, ser_in,
                  input  dout, dout_valid, busy, par_err);
  modport slave  (input  ena_in, ser_in,
                  output dout, dout_valid, busy, par_err);
endinterface

// File: rtl/serie_paralelo.sv
// Serial-to-parallel converter. Collects WIDTH bits, LSB first, starting at an
// ena_in strobe, and presents them as a registered word with a one-cycle
// dout_valid pulse. An ena_in during a frame restarts collection from bit 0.
// Optional feature: define SERIE_PARALELO_PARITY_EN to expect one even-parity
// bit after the last data bit; par_err then reports the parity check result.
// Ports:
//   clk   rising-edge clock
//   clr_n asynchronous active-low clear
//   bus   serie_paralelo_if.slave (ena_in, ser_in -> dout, dout_valid, busy, par_err)
module serie_paralelo #(
  parameter int WIDTH = 6
) (
  input  logic           clk,
  input  logic           clr_n,
  serie_paralelo_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIE_PARALELO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} st_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} st_t;
`endif

  st_t              state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] dout_q;
  logic             vld_q;
  logic             load;
`ifdef SERIE_PARALELO_PARITY_EN
  logic             perr_q, perr_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    load      = 1'b0;
`ifdef SERIE_PARALELO_PARITY_EN
    perr_nxt  = 1'b0;
`endif
    if (bus.ena_in) begin
      // Start of frame from any state; a partial frame is simply dropped.
      sreg_nxt[0] = bus.ser_in;
      cnt_nxt     = CW'(1);
      state_nxt   = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          for (int i = 0; i < WIDTH; i++)
            if (cnt == CW'(i)) sreg_nxt[i] = bus.ser_in;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIE_PARALELO_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            cnt_nxt   = '0;
            load      = 1'b1;
`endif
          end
        end
`ifdef SERIE_PARALELO_PARITY_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          load      = 1'b1;
          perr_nxt  = (^sreg) ^ bus.ser_in;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
`ifdef SERIE_PARALELO_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
      vld_q <= load;
      if (load) dout_q <= sreg_nxt;
`ifdef SERIE_PARALELO_PARITY_EN
      perr_q <= perr_nxt;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.busy       = (state != IDLE);
`ifdef SERIE_PARALELO_PARITY_EN
  assign bus.par_err    = perr_q;
`else
  assign bus.par_err    = 1'b0;
`endif
endmodule

// File: doc/serie_paralelo.md
SERIE_PARALELO -- requirements
Module: serie_paralelo

Interface
REQ-001 Parameter WIDTH, default 6, data word width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 ena_in  input  1  frame-start strobe; high in the cycle that carries data bit 0.
REQ-005 ser_in  input  1  serial data, LSB first, one bit per clk cycle.
REQ-006 dout  output  WIDTH  last completed parallel word, registered.
REQ-007 dout_valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-008 busy  output  1  high while a frame is being collected.
REQ-009 par_err  output  1  parity error flag, valid with dout_valid; port always present.

Function
REQ-010 The block SHALL implement states IDLE, SHIFT and, with the macro of REQ-025, PARITY.
REQ-011 In IDLE with ena_in=1 at a rising edge, the block SHALL sample ser_in as bit 0, load bit counter with 1, and enter SHIFT.
REQ-012 In IDLE with ena_in=0, ser_in SHALL be ignored and all registers SHALL hold.
REQ-013 In SHIFT, each edge SHALL store ser_in at index = counter and increment counter; the counter is ceil(log2(WIDTH+1)) bits, unsigned.
REQ-014 At the edge sampling bit WIDTH-1, the block SHALL transfer the shift register to dout, pulse dout_valid for the following cycle, and return to IDLE (or enter PARITY per REQ-026).
REQ-015 Latency SHALL be: ena_in at cycle 0 -> dout_valid high in cycle WIDTH (no parity) or WIDTH+1 (parity).
REQ-016 dout SHALL hold its value between frames; it SHALL change only in dout_valid cycles.
REQ-017 busy SHALL be high in every cycle whose state is SHIFT or PARITY, low in IDLE.
REQ-018 ena_in=1 while in SHIFT or PARITY SHALL abort the partial frame (no dout_valid, dout unchanged), treat the current ser_in as bit 0 of a new frame, and reload counter with 1.
REQ-019 ena_in=1 in the cycle dout_valid is high SHALL start a new frame with no idle gap (back-to-back frames, period WIDTH or WIDTH+1 cycles).
REQ-020 par_err SHALL be 0 outside dout_valid cycles.

Reset
REQ-021 clr_n=0 SHALL immediately, without clock, force state IDLE, counter 0, shift register 0.
REQ-022 Reset values: dout=0, dout_valid=0, busy=0, par_err=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; no dout_valid SHALL be produced for it.
REQ-024 After clr_n deasserts, the first rising edge SHALL already accept ena_in.

Configuration
REQ-025 Macro SERIE_PARALELO_PARITY_EN SHALL control an even-parity bit following data bit WIDTH-1.
REQ-026 With the macro defined: after the last data bit, the block SHALL enter PARITY for one cycle, sample ser_in as parity, then load dout, pulse dout_valid and set par_err = XOR of data bits and parity bit.
REQ-027 Without the macro: no PARITY state, par_err SHALL be tied to 0, timing per REQ-015 no-parity case.

Verification
REQ-028 WIDTH=6, no macro: ena_in at cycle 0, ser_in 1,0,1,1,0,1 in cycles 0..5 -> dout=6'h2D, dout_valid=1 in cycle 6 only, busy high cycles 1..5.
REQ-029 Back-to-back: second frame 0,1,0,0,1,0 starting with ena_in in cycle 6 -> dout=6'h12 with dout_valid in cycle 12; dout stays 6'h2D in cycles 7..11.
REQ-030 Resync: ena_in at cycle 0, again at cycle 3, then bits 1,1,1,1,1,1 from cycle 3 -> no valid at cycle 6, dout=6'h3F valid in cycle 9.
REQ-031 Reset mid-frame: clr_n low in cycle 3 of a frame -> dout=0, busy=0 immediately; no dout_valid afterwards until a new ena_in.
REQ-032 With SERIE_PARALELO_PARITY_EN: 6'h2D plus parity 0 -> dout_valid in cycle 7, par_err=0; same data plus parity 1 -> par_err=1 in cycle 7 only.
